// File: rtl/logic_gate_unit.sv
// Bitwise logic unit: eight ops over two WIDTH-bit operands with a 2-entry in-order
// result buffer on valid/ready handshakes, plus a saturating completed-pop counter.
module logic_gate_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             y_all,
    output logic             y_any,
    output logic             err,
    output logic [CNT_W-1:0] op_count
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             err;
        logic             all;
        logic             any;
    } entry_t;

    entry_t           head_q, head_d, tail_q, tail_d, new_entry;
    logic             head_vld_q, head_vld_d, tail_vld_q, tail_vld_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [WIDTH-1:0] res;
    logic             push, pop;

    // Operation decode; every code is covered so no X can leak into the buffer.
    always_comb begin
        res           = '0;
        new_entry     = '0;
        case (op)
            3'b000:  res = a & b;
            3'b001:  res = a | b;
            3'b010:  res = ~(a & b);
            3'b011:  res = ~(a | b);
            3'b100:  res = a ^ b;
            3'b101:  res = ~(a ^ b);
            3'b110:  res = ~a;
            default: res = '0;
        endcase
        new_entry.y   = res;
        new_entry.err = (op == 3'b111);
        new_entry.all = &res;
        new_entry.any = |res;
    end

    // The buffer is kept compacted: a valid tail always implies a valid head.
    assign in_ready  = ~tail_vld_q;
    assign out_valid = head_vld_q;
    assign push      = in_valid & in_ready;
    assign pop       = head_vld_q & out_ready;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        head_vld_d = head_vld_q;
        tail_vld_d = tail_vld_q;
        op_count_d = op_count_q;
        if (pop) begin
            if (tail_vld_q) begin
                head_d     = tail_q;
                tail_d     = '0;
                tail_vld_d = 1'b0;
            end else if (push) begin
                head_d     = new_entry;
            end else begin
                head_d     = '0;
                head_vld_d = 1'b0;
            end
        end else if (push) begin
            if (head_vld_q) begin
                tail_d     = new_entry;
                tail_vld_d = 1'b1;
            end else begin
                head_d     = new_entry;
                head_vld_d = 1'b1;
            end
        end
        if (pop && (op_count_q != {CNT_W{1'b1}})) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            head_vld_q <= 1'b0;
            tail_vld_q <= 1'b0;
            op_count_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            head_vld_q <= head_vld_d;
            tail_vld_q <= tail_vld_d;
            op_count_q <= op_count_d;
        end
    end

    // Empty head entry is all-zero, so outputs read 0 whenever out_valid is low.
    assign y        = head_q.y;
    assign err      = head_q.err;
    assign y_all    = head_q.all;
    assign y_any    = head_q.any;
    assign op_count = op_count_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed-plus-random bench for logic_gate_unit; outputs are compared every cycle
// against a queue-based reference built from per-op truth tables.
module tb_logic_gate_unit;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             y_all, y_any, err;
    logic [CNT_W-1:0] op_count;

    logic_gate_unit #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .y_all(y_all), .y_any(y_any), .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             err;
    } ent_t;

    ent_t q[$];
    int   pops_model;
    int   vectors;
    int   miscompares;

    function automatic ent_t ref_op(logic [WIDTH-1:0] ra, logic [WIDTH-1:0] rb, logic [2:0] rop);
        ent_t       r;
        logic [3:0] tt;
        // truth table indexed by {a_bit, b_bit}
        case (rop)
            3'd0:    tt = 4'b1000;
            3'd1:    tt = 4'b1110;
            3'd2:    tt = 4'b0111;
            3'd3:    tt = 4'b0001;
            3'd4:    tt = 4'b0110;
            3'd5:    tt = 4'b1001;
            3'd6:    tt = 4'b0011;
            default: tt = 4'b0000;
        endcase
        for (int i = 0; i < int'(WIDTH); i++) r.y[i] = tt[{ra[i], rb[i]}];
        r.err = (rop == 3'd7);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [WIDTH-1:0] ia,
                        input logic [WIDTH-1:0] ib, input logic [2:0] iop, input logic ordy);
        bit       do_push, do_pop;
        ent_t     h;
        int       max_cnt;
        @(negedge clk);
        rst = r; in_valid = iv; a = ia; b = ib; op = iop; out_ready = ordy;
        do_push = iv && (q.size() < 2);
        do_pop  = ordy && (q.size() > 0);
        @(posedge clk);
        max_cnt = (1 << CNT_W) - 1;
        if (r) begin
            q.delete();
            pops_model = 0;
        end else begin
            if (do_pop) begin
                void'(q.pop_front());
                if (pops_model < max_cnt) pops_model++;
            end
            if (do_push) q.push_back(ref_op(ia, ib, iop));
        end
        #1;
        h = (q.size() > 0) ? q[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        chk("y",         32'(y),         32'(h.y));
        chk("err",       32'(err),       32'(h.err));
        chk("y_all",     32'(y_all),     32'((q.size() > 0) && (h.y == {WIDTH{1'b1}})));
        chk("y_any",     32'(y_any),     32'(h.y != '0));
        chk("op_count",  32'(op_count),  32'(pops_model));
    endtask

    function automatic logic [WIDTH-1:0] rnd();
        return WIDTH'($urandom);
    endfunction

    logic [WIDTH-1:0] sweep_exp [8];
    logic [WIDTH-1:0] ra3, rb3;
    logic [2:0]       rop3;

    initial begin
        vectors = 0; miscompares = 0; pops_model = 0;
        sweep_exp = '{8'h0A, 8'hAF, 8'hF5, 8'h50, 8'hA5, 8'h5A, 8'h55, 8'h00};
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready",  32'(in_ready),  32'(1));

        // single AND with one-cycle latency
        step(0, 1, 8'hF0, 8'h3C, 3'd0, 1);
        chk("single_y",     32'(y),         32'h30);
        chk("single_valid", 32'(out_valid), 32'(1));
        chk("single_any",   32'(y_any),     32'(1));
        chk("single_all",   32'(y_all),     32'(0));
        chk("single_err",   32'(err),       32'(0));
        step(0, 0, '0, '0, 3'd0, 1);
        chk("single_cnt",   32'(op_count),  32'(1));

        // all ops streamed; each push replaces the popped head
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'hAA, 8'h0F, 3'(i), 1);
            chk("sweep_y",   32'(y),   32'(sweep_exp[i]));
            chk("sweep_err", 32'(err), 32'(i == 7));
        end
        step(0, 0, '0, '0, 3'd0, 1);

        // backpressure: third operand is held until space frees up
        out_ready = 1'b0;
        step(0, 1, rnd(), rnd(), 3'($urandom_range(0, 7)), 0);
        step(0, 1, rnd(), rnd(), 3'($urandom_range(0, 7)), 0);
        chk("bp_full", 32'(in_ready), 32'(0));
        ra3 = rnd(); rb3 = rnd(); rop3 = 3'($urandom_range(0, 7));
        repeat (2) step(0, 1, ra3, rb3, rop3, 0);
        repeat (4) step(0, 1, ra3, rb3, rop3, 1);
        repeat (2) step(0, 0, '0, '0, 3'd0, 1);

        // streaming random operands
        for (int i = 0; i < 20; i++)
            step(0, 1, rnd(), rnd(), 3'($urandom_range(0, 7)), 1);
        step(0, 0, '0, '0, 3'd0, 1);

        // random valid/ready mix
        for (int i = 0; i < 30; i++)
            step(0, 1'($urandom), rnd(), rnd(), 3'($urandom_range(0, 7)), 1'($urandom));

        // reset with a full buffer and an operand presented
        step(0, 1, rnd(), rnd(), 3'd1, 0);
        step(0, 1, rnd(), rnd(), 3'd4, 0);
        step(0, 1, rnd(), rnd(), 3'd5, 0);
        step(1, 1, 8'hFF, 8'hFF, 3'd0, 0);
        chk("mid_rst_valid", 32'(out_valid), 32'(0));
        chk("mid_rst_ready", 32'(in_ready),  32'(1));
        chk("mid_rst_cnt",   32'(op_count),  32'(0));
        chk("mid_rst_y",     32'(y),         32'(0));
        repeat (3) step(0, 0, '0, '0, 3'd0, 1);

        // counter saturation after 10 pops
        for (int i = 0; i < 10; i++)
            step(0, 1, rnd(), rnd(), 3'($urandom_range(0, 7)), 1);
        step(0, 0, '0, '0, 3'd0, 1);
        chk("sat_cnt", 32'(op_count), 32'(7));
        repeat (2) step(0, 1, rnd(), rnd(), 3'd2, 1);
        step(0, 0, '0, '0, 3'd0, 1);
        chk("sat_hold", 32'(op_count), 32'(7));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
